// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: datapath width, load/store funct3 codes and
// the memory-stage access FSM encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } mem_state_e;

    function automatic logic load_f3_legal(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic store_f3_legal(input logic [2:0] f3);
        return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the data-memory port: store enables/replication,
// load extract/extend, and detection of misaligned or illegal accesses.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] load_data_o,
    output logic            bad_access_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        misaligned;
    logic        illegal;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = store_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = store_data_i;
            end
        endcase
    end

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        load_data_o = rdata_i;
        case (funct3_i)
            F3_LB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  load_data_o = {24'd0, byte_sel};
            F3_LHU:  load_data_o = {16'd0, half_sel};
            default: load_data_o = rdata_i;
        endcase
    end

    // Size lives in funct3[1:0]; code 11 is rejected as illegal before alignment matters.
    assign misaligned = ((funct3_i[1:0] == 2'b01) && addr_lo_i[0]) ||
                        ((funct3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));

    assign illegal = mem_read_i  ? !load_f3_legal(funct3_i)  :
                     mem_write_i ? !store_f3_legal(funct3_i) : 1'b0;

    assign bad_access_o = (mem_read_i || mem_write_i) && (illegal || misaligned);

endmodule

// File: rtl/mem_stage.sv
// RV32 memory-access stage: one outstanding req/gnt/rvalid access at a time,
// upstream stalled until the access completes, MEM/WB fields registered here.
module mem_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_funct3,
    output logic            mem_stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic            wb_reg_write,
    output logic            wb_mem_to_reg,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [XLEN-1:0] wb_read_data,
    output logic            misalign_exc
);

    mem_state_e      state_q;

    logic            mem_op;
    logic            bad_access;
    logic            bad_op;
    logic            aligned_op;
    logic            req;
    logic            stall;
    logic [3:0]      lane_be;
    logic [XLEN-1:0] lane_wdata;
    logic [XLEN-1:0] load_data;

    logic            wb_valid_q,      wb_valid_d;
    logic            wb_reg_write_q,  wb_reg_write_d;
    logic            wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [4:0]      wb_rd_q,         wb_rd_d;
    logic [XLEN-1:0] wb_alu_result_q, wb_alu_result_d;
    logic [XLEN-1:0] wb_read_data_q,  wb_read_data_d;
    logic            misalign_exc_q,  misalign_exc_d;

    lsu_align u_align (
        .addr_lo_i    (ex_alu_result[1:0]),
        .funct3_i     (ex_funct3),
        .mem_read_i   (ex_mem_read),
        .mem_write_i  (ex_mem_write),
        .store_data_i (ex_store_data),
        .rdata_i      (dmem_rdata),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .load_data_o  (load_data),
        .bad_access_o (bad_access)
    );

    assign mem_op     = ex_valid && (ex_mem_read || ex_mem_write);
    assign bad_op     = mem_op && bad_access;
    assign aligned_op = mem_op && !bad_access;

    // Upstream holds ex_* stable while stalled, so REQ/WAIT_R can keep using them.
    always_comb begin
        req   = 1'b0;
        stall = 1'b0;
        case (state_q)
            IDLE: begin
                req   = aligned_op;
                stall = aligned_op && !(ex_mem_write && dmem_gnt);
            end
            REQ: begin
                req   = 1'b1;
                stall = !(ex_mem_write && dmem_gnt);
            end
            WAIT_R: begin
                req   = 1'b0;
                stall = !dmem_rvalid;
            end
            default: begin
                req   = 1'b0;
                stall = 1'b0;
            end
        endcase
    end

    assign dmem_req   = req && !reset;
    assign dmem_we    = dmem_req && ex_mem_write;
    assign dmem_be    = dmem_req ? lane_be : 4'b0000;
    assign dmem_addr  = {ex_alu_result[XLEN-1:2], 2'b00};
    assign dmem_wdata = lane_wdata;
    assign mem_stall  = stall && !reset;

    // rvalid only matters in WAIT_R; one coincident with gnt is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aligned_op) begin
                        if (dmem_gnt) state_q <= ex_mem_read ? WAIT_R : IDLE;
                        else          state_q <= REQ;
                    end
                end
                REQ: begin
                    if (dmem_gnt) state_q <= ex_mem_read ? WAIT_R : IDLE;
                end
                WAIT_R: begin
                    if (dmem_rvalid) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        wb_valid_d      = 1'b0;
        wb_reg_write_d  = 1'b0;
        wb_mem_to_reg_d = wb_mem_to_reg_q;
        wb_rd_d         = wb_rd_q;
        wb_alu_result_d = wb_alu_result_q;
        wb_read_data_d  = wb_read_data_q;
        misalign_exc_d  = 1'b0;
        if (!stall) begin
            wb_valid_d      = ex_valid && !bad_op;
            wb_reg_write_d  = ex_valid && !bad_op && ex_reg_write && (ex_rd != 5'd0);
            wb_mem_to_reg_d = ex_valid && ex_mem_read;
            wb_rd_d         = ex_rd;
            wb_alu_result_d = ex_alu_result;
            wb_read_data_d  = ex_mem_read ? load_data : '0;
            misalign_exc_d  = bad_op;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_rd_q         <= '0;
            wb_alu_result_q <= '0;
            wb_read_data_q  <= '0;
            misalign_exc_q  <= 1'b0;
        end else begin
            wb_valid_q      <= wb_valid_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_rd_q         <= wb_rd_d;
            wb_alu_result_q <= wb_alu_result_d;
            wb_read_data_q  <= wb_read_data_d;
            misalign_exc_q  <= misalign_exc_d;
        end
    end

    assign wb_valid      = wb_valid_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_mem_to_reg = wb_mem_to_reg_q;
    assign wb_rd         = wb_rd_q;
    assign wb_alu_result = wb_alu_result_q;
    assign wb_read_data  = wb_read_data_q;
    assign misalign_exc  = misalign_exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected bus requests and
// MEM/WB results; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_read_data;
    logic        misalign_exc;

    mem_stage dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_funct3     (ex_funct3),
        .mem_stall     (mem_stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_gnt      (dmem_gnt),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_rd         (wb_rd),
        .wb_alu_result (wb_alu_result),
        .wb_read_data  (wb_read_data),
        .misalign_exc  (misalign_exc)
    );

    typedef struct {
        logic        valid;
        logic        regw;
        logic        m2r;
        logic        exc;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_exp_t;

    wb_exp_t  wbq[$];
    req_exp_t reqq[$];
    int       n_tests = 0;
    int       n_fail  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic exp_wb(input logic valid, input logic regw, input logic m2r, input logic exc,
                          input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata);
        wb_exp_t e;
        e.valid = valid; e.regw = regw; e.m2r = m2r; e.exc = exc;
        e.rd = rd; e.alu = alu; e.rdata = rdata;
        wbq.push_back(e);
    endtask

    task automatic exp_req(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wdata);
        req_exp_t r;
        r.addr = addr; r.we = we; r.be = be; r.wdata = wdata;
        reqq.push_back(r);
    endtask

    // Monitor: checks every granted request and every MEM/WB retirement/exception.
    always @(negedge clk) begin
        req_exp_t r;
        wb_exp_t  e;
        if (!reset) begin
            if (dmem_req) begin
                if (reqq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_req: got addr %h expected no request", dmem_addr);
                end else if (dmem_gnt) begin
                    r = reqq.pop_front();
                    chk("req_addr", dmem_addr, r.addr);
                    chk("req_we", {31'd0, dmem_we}, {31'd0, r.we});
                    if (r.we) begin
                        chk("req_be", {28'd0, dmem_be}, {28'd0, r.be});
                        chk("req_wdata", dmem_wdata, r.wdata);
                    end
                end
            end
            if (wb_valid || misalign_exc) begin
                if (wbq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_wb: got valid %b exc %b expected nothing", wb_valid, misalign_exc);
                end else begin
                    e = wbq.pop_front();
                    chk("wb_valid", {31'd0, wb_valid}, {31'd0, e.valid});
                    chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.regw});
                    chk("misalign_exc", {31'd0, misalign_exc}, {31'd0, e.exc});
                    if (e.valid) begin
                        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                        chk("wb_alu_result", wb_alu_result, e.alu);
                        chk("wb_mem_to_reg", {31'd0, wb_mem_to_reg}, {31'd0, e.m2r});
                        if (e.m2r) chk("wb_read_data", wb_read_data, e.rdata);
                    end
                end
            end
        end
    end

    // Drives one EX/MEM instruction; gnt_dly<0 means no grant, rv_dly counts from the grant cycle.
    task automatic run_op(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                          input logic regw, input int gnt_dly, input int rv_dly,
                          input logic [31:0] rdata, input int exp_stall);
        int cyc;
        int stalls;
        bit done;
        cyc = 0; stalls = 0; done = 1'b0;
        ex_valid = 1'b1; ex_mem_read = ld; ex_mem_write = st; ex_funct3 = f3;
        ex_alu_result = addr; ex_store_data = sdata; ex_rd = rd; ex_reg_write = regw;
        while (!done && cyc < 50) begin
            dmem_gnt    = (gnt_dly >= 0) && (cyc == gnt_dly);
            dmem_rvalid = (gnt_dly >= 0) && (rv_dly > 0) && (cyc == gnt_dly + rv_dly);
            dmem_rdata  = dmem_rvalid ? rdata : 32'hDEADBEEF;
            @(negedge clk);
            if (mem_stall) stalls++;
            else done = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'hDEADBEEF;
        chk({nm, "_done"}, {31'd0, done}, 32'd1);
        chk({nm, "_stall"}, stalls, exp_stall);
    endtask

    initial begin
        reset = 1'b1;
        ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_rd = '0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'hDEADBEEF;

        repeat (2) @(negedge clk);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
        chk("rst_wb_mem_to_reg", {31'd0, wb_mem_to_reg}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_alu_result", wb_alu_result, 32'd0);
        chk("rst_wb_read_data", wb_read_data, 32'd0);
        chk("rst_misalign_exc", {31'd0, misalign_exc}, 32'd0);
        chk("rst_dmem", {26'd0, dmem_req, dmem_we, dmem_be}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // ALU op
        exp_wb(1, 1, 0, 0, 5'd5, 32'h0000_1234, 32'h0);
        run_op("alu", 0, 0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1, -1, -1, 32'h0, 0);

        // SB to lane 3, immediate grant
        exp_req(32'h0000_0100, 1, 4'b1000, 32'hABAB_ABAB);
        exp_wb(1, 0, 0, 0, 5'd7, 32'h0000_0103, 32'h0);
        run_op("sb", 0, 1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 5'd7, 0, 0, -1, 32'h0, 0);

        // LB / LBU lane 2, gnt after 2 cycles, rvalid 3 cycles later
        exp_req(32'h0000_0100, 0, 4'b0000, 32'h0);
        exp_wb(1, 1, 1, 0, 5'd10, 32'h0000_0102, 32'hFFFF_FF80);
        run_op("lb", 1, 0, 3'b000, 32'h0000_0102, 32'h0, 5'd10, 1, 2, 3, 32'h0080_0000, 5);
        exp_req(32'h0000_0100, 0, 4'b0000, 32'h0);
        exp_wb(1, 1, 1, 0, 5'd11, 32'h0000_0102, 32'h0000_0080);
        run_op("lbu", 1, 0, 3'b100, 32'h0000_0102, 32'h0, 5'd11, 1, 2, 3, 32'h0080_0000, 5);

        // Misaligned LW: no request, single exception pulse
        exp_wb(0, 0, 0, 1, 5'd12, 32'h0000_0006, 32'h0);
        run_op("lw_mis", 1, 0, 3'b010, 32'h0000_0006, 32'h0, 5'd12, 1, -1, -1, 32'h0, 0);

        // LW to x0, fastest load (rvalid the cycle after grant)
        exp_req(32'h0000_0010, 0, 4'b0000, 32'h0);
        exp_wb(1, 0, 1, 0, 5'd0, 32'h0000_0010, 32'h1234_5678);
        run_op("lw_x0", 1, 0, 3'b010, 32'h0000_0010, 32'h0, 5'd0, 1, 0, 1, 32'h1234_5678, 1);

        // SH upper half, SW granted after 2 wait cycles
        exp_req(32'h0000_0100, 1, 4'b1100, 32'hBEEF_BEEF);
        exp_wb(1, 0, 0, 0, 5'd0, 32'h0000_0102, 32'h0);
        run_op("sh", 0, 1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 5'd0, 0, 0, -1, 32'h0, 0);
        exp_req(32'h0000_0204, 1, 4'b1111, 32'hCAFE_F00D);
        exp_wb(1, 0, 0, 0, 5'd0, 32'h0000_0204, 32'h0);
        run_op("sw", 0, 1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 5'd0, 0, 2, -1, 32'h0, 2);

        // LH / LHU upper half
        exp_req(32'h0000_0000, 0, 4'b0000, 32'h0);
        exp_wb(1, 1, 1, 0, 5'd13, 32'h0000_0002, 32'hFFFF_8001);
        run_op("lh", 1, 0, 3'b001, 32'h0000_0002, 32'h0, 5'd13, 1, 1, 1, 32'h8001_5A5A, 2);
        exp_req(32'h0000_0000, 0, 4'b0000, 32'h0);
        exp_wb(1, 1, 1, 0, 5'd14, 32'h0000_0002, 32'h0000_8001);
        run_op("lhu", 1, 0, 3'b101, 32'h0000_0002, 32'h0, 5'd14, 1, 0, 1, 32'h8001_5A5A, 1);

        // Illegal funct3 codes and a misaligned SH
        exp_wb(0, 0, 0, 1, 5'd15, 32'h0, 32'h0);
        run_op("ld_ill", 1, 0, 3'b011, 32'h0000_0000, 32'h0, 5'd15, 1, -1, -1, 32'h0, 0);
        exp_wb(0, 0, 0, 1, 5'd0, 32'h0, 32'h0);
        run_op("st_ill", 0, 1, 3'b100, 32'h0000_0000, 32'h0, 5'd0, 0, -1, -1, 32'h0, 0);
        exp_wb(0, 0, 0, 1, 5'd0, 32'h0, 32'h0);
        run_op("sh_mis", 0, 1, 3'b001, 32'h0000_0101, 32'h0, 5'd0, 0, -1, -1, 32'h0, 0);

        // Reset while a load waits for rvalid; the late rvalid must not retire anything
        exp_req(32'h0000_0020, 0, 4'b0000, 32'h0);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = 3'b010;
        ex_alu_result = 32'h0000_0020; ex_rd = 5'd9; ex_reg_write = 1'b1;
        dmem_gnt = 1'b1;
        @(negedge clk);
        chk("rst_seq_stall_g", {31'd0, mem_stall}, 32'd1);
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(negedge clk);
        chk("rst_seq_stall_w", {31'd0, mem_stall}, 32'd1);
        #1;
        reset = 1'b1;
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        #1;
        chk("rst_seq_stall_r", {31'd0, mem_stall}, 32'd0);
        chk("rst_seq_wb_valid", {31'd0, wb_valid}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0; dmem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rst_seq_wb_after", {30'd0, wb_valid, wb_reg_write}, 32'd0);
        chk("rst_seq_stall_after", {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1;

        exp_wb(1, 1, 0, 0, 5'd3, 32'h0000_BEEF, 32'h0);
        run_op("alu_post", 0, 0, 3'b000, 32'h0000_BEEF, 32'h0, 5'd3, 1, -1, -1, 32'h0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("wbq_drained", wbq.size(), 32'd0);
        chk("reqq_drained", reqq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RISC-V pipeline, between execute and writeback. It takes the EX/MEM instruction fields and, for loads and stores, issues a single request on a req/gnt/rvalid data-memory port, with byte-lane alignment on both paths. It stalls upstream while a memory access is outstanding and registers the MEM/WB fields that the writeback stage consumes.

## Interface
- XLEN, 32: datapath width; only 32 is supported.
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high.
- ex_valid  in  1  an instruction is present in EX/MEM.
- ex_alu_result  in  32  ALU result, used as the effective address for memory ops.
- ex_store_data  in  32  rs2 value for stores.
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  instruction writes rd.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store; never asserted together with ex_mem_read.
- ex_funct3  in  3  access size and sign.
- mem_stall  out  1  freeze IF/ID/EX; upstream holds all ex_* stable while this is high.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  32  load word.
- wb_valid  out  1  MEM/WB holds a retiring instruction.
- wb_reg_write  out  1  write rd.
- wb_mem_to_reg  out  1  select wb_read_data rather than wb_alu_result.
- wb_rd  out  5  destination register.
- wb_alu_result  out  32  forwarded ALU result.
- wb_read_data  out  32  aligned and extended load data.
- misalign_exc  out  1  one-cycle pulse: misaligned or illegal memory access.

## Operation
- An instruction is a memory op when ex_valid & (ex_mem_read | ex_mem_write).
- **Legal funct3 codes**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code on a memory op is illegal.
- **Misaligned access:** a halfword with addr[0]=1, or a word with addr[1:0]≠0.
- **Misaligned or illegal op**
  - No request is issued and no stall is raised.
  - At the next edge: wb_valid=0, wb_reg_write=0, misalign_exc=1 for one cycle.
- **FSM state IDLE**
  - dmem_req is driven combinationally for an aligned memory op.
  - Store with gnt: completes this cycle, no stall.
  - Load with gnt: go to WAIT_R.
  - No gnt: go to REQ.
- **FSM state REQ**
  - dmem_req is held with stable addr/we/be/wdata until gnt.
  - On gnt: a store completes (go to IDLE); a load goes to WAIT_R.
- **FSM state WAIT_R**
  - dmem_req=0.
  - On dmem_rvalid the load completes; go to IDLE.
- dmem_rvalid is ignored outside WAIT_R. Only one access is outstanding at a time.
- **mem_stall** is high whenever an aligned memory op cannot complete in the current cycle.
- **Store lanes**
  - SB: be = 0001 << addr[1:0], byte replicated ×4.
  - SH: be = 0011 << addr[1:0], half replicated ×2.
  - SW: be = 1111.
- **Load extract:** select the byte/half of dmem_rdata by addr[1:0]; sign-extend (LB, LH) or zero-extend (LBU, LHU).
- **MEM/WB register**
  - Updates on every edge where mem_stall=0.
  - ex_valid=0 loads a bubble.
  - While stalled, wb_valid=0 and wb_reg_write=0 each cycle; data fields hold.
- wb_reg_write = ex_reg_write & (ex_rd≠0); x0 is never written.
- wb_mem_to_reg = ex_mem_read.

## Timing
- **Reset values:** all wb_* = 0, misalign_exc=0, dmem_req/dmem_we/dmem_be=0, state IDLE.
- **Reset mid-access:** state forced to IDLE; a late rvalid or gnt is ignored; no writeback occurs.
- **Latency, EX/MEM → MEM/WB**
  - ALU op: 1 cycle.
  - Store granted in the first cycle: 1 cycle.
  - Store granted after n wait cycles: n+1 cycles.
  - Load: granted cycle g, rvalid cycle r; earliest is r=g+1.
  - Load stall: mem_stall is high from the first cycle through r-1 and low in cycle r; MEM/WB latches at the end of cycle r.
- **Simultaneous events:** gnt in IDLE and REQ is honoured in the same cycle; rvalid coincident with gnt is a protocol violation and is ignored.

## Structure
- **Shared package riscv_pkg:** XLEN, the load/store funct3 localparams, and the FSM state enum (IDLE, REQ, WAIT_R).
- **Sub-module lsu_align (combinational):** store be/wdata generation, load extract/extend, and the misalign/illegal flag.

## Test plan
- **ALU op:** ex_alu_result=0x1234, rd=5 → next cycle wb_valid=1, wb_reg_write=1, wb_alu_result=0x1234, mem_stall=0 throughout.
- **SB:** addr 0x103, data 0xAB, gnt immediate → dmem_be=1000, dmem_wdata=0xABABABAB, dmem_addr=0x100, no stall.
- **LB:** addr 0x102, gnt after 2 cycles, rvalid 3 cycles later, rdata=0x00800000 → mem_stall high 5 cycles, wb_read_data=0xFFFFFF80. Repeat as LBU → 0x00000080.
- **LW at 0x006** → no dmem_req, misalign_exc pulses once, wb_reg_write=0, no stall.
- **Reset in WAIT_R**, then rvalid → all wb_* stay 0, state IDLE; a following ALU op retires normally.
- **rd=0 on an LW** → load completes but wb_reg_write=0.
